// File: rtl/avmm_vram_arbiter.sv
// avmm_vram_arbiter: VGA-priority arbiter for a single-port VRAM with a tag pipeline that routes read data back to its owner.
module avmm_vram_arbiter #(
  parameter int PWIDTH    = 8,
  parameter int AWIDTH    = 19,
  parameter int LATENCY   = 2,
  parameter int VGA_BURST = 8
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic [AWIDTH-1:0] vga_address,
  input  logic              vga_read,
  output logic              vga_waitrequest,
  output logic [PWIDTH-1:0] vga_readdata,
  output logic              vga_readdatavalid,
  input  logic [AWIDTH-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [PWIDTH-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [PWIDTH-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [PWIDTH-1:0] ram_wdata,
  input  logic [PWIDTH-1:0] ram_rdata
);
  localparam int SW = $clog2(VGA_BURST + 1);
  localparam int NS = LATENCY + 1;
  localparam logic [SW-1:0] BURST = SW'(VGA_BURST);
  logic              cpu_pend, grant_vga, grant_cpu, ram_rd_d, ram_wr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [NS-1:0]     tag_valid_q, tag_cpu_q;
  logic [AWIDTH-1:0] ram_addr_q;
  logic [PWIDTH-1:0] ram_wdata_q, vga_rdata_q, cpu_rdata_q;
  logic              ram_rd_q, ram_wr_q, vga_rdv_q, cpu_rdv_q;
  always_comb begin
    cpu_pend  = cpu_read | cpu_write;
    grant_vga = !rst_core && vga_read && !(cpu_pend && starve_q == BURST);
    grant_cpu = !rst_core && cpu_pend && !grant_vga;
    ram_rd_d  = grant_vga | (grant_cpu & ~cpu_write);
    ram_wr_d  = grant_cpu & cpu_write;
    starve_d  = (!cpu_pend || grant_cpu) ? '0 :
                (grant_vga && starve_q != BURST) ? starve_q + SW'(1) : starve_q;
  end
  assign vga_waitrequest   = rst_core | (vga_read & ~grant_vga);
  assign cpu_waitrequest   = rst_core | (cpu_pend & ~grant_cpu);
  assign ram_addr          = ram_addr_q;
  assign ram_rd            = ram_rd_q;
  assign ram_wr            = ram_wr_q;
  assign ram_wdata         = ram_wdata_q;
  assign vga_readdata      = vga_rdata_q;
  assign vga_readdatavalid = vga_rdv_q;
  assign cpu_readdata      = cpu_rdata_q;
  assign cpu_readdatavalid = cpu_rdv_q;
  // Last tag stage lines up with ram_rdata being valid; its owner latches the data.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      starve_q    <= '0;
      tag_valid_q <= '0;
      tag_cpu_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
      vga_rdv_q   <= 1'b0;
      cpu_rdv_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      if (grant_vga | grant_cpu) ram_addr_q <= grant_vga ? vga_address : cpu_address;
      if (ram_wr_d) ram_wdata_q <= cpu_writedata;
      tag_valid_q <= {tag_valid_q[NS-2:0], ram_rd_d};
      tag_cpu_q   <= {tag_cpu_q[NS-2:0], grant_cpu};
      vga_rdv_q   <= tag_valid_q[NS-1] & ~tag_cpu_q[NS-1];
      cpu_rdv_q   <= tag_valid_q[NS-1] & tag_cpu_q[NS-1];
      if (tag_valid_q[NS-1] && !tag_cpu_q[NS-1]) vga_rdata_q <= ram_rdata;
      if (tag_valid_q[NS-1] && tag_cpu_q[NS-1]) cpu_rdata_q <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_avmm_vram_arbiter.sv
// tb_avmm_vram_arbiter: scoreboard bench with a behavioural fixed-latency RAM and per-scenario tasks.
module tb_avmm_vram_arbiter;
  localparam int LAT = 2;
  typedef struct {logic [7:0] d; int c;} exp_t;
  logic        clk = 0, rst = 1;
  logic [18:0] vga_address = 0, cpu_address = 0, ram_addr;
  logic        vga_read = 0, cpu_read = 0, cpu_write = 0;
  logic [7:0]  cpu_writedata = 0, vga_readdata, cpu_readdata, ram_wdata, ram_rdata;
  logic        vga_waitrequest, vga_readdatavalid, cpu_waitrequest, cpu_readdatavalid, ram_rd, ram_wr;
  logic [7:0]  mem [int];
  logic [7:0]  ref_mem [int];
  logic [7:0]  pipe [LAT];
  exp_t        vq[$], cq[$];
  int          checks = 0, failures = 0, cyc = 0, vga_pulses = 0, cpu_pulses = 0;

  avmm_vram_arbiter #(.PWIDTH(8), .AWIDTH(19), .LATENCY(LAT), .VGA_BURST(8)) dut (
    .clk_core(clk), .rst_core(rst),
    .vga_address(vga_address), .vga_read(vga_read), .vga_waitrequest(vga_waitrequest),
    .vga_readdata(vga_readdata), .vga_readdatavalid(vga_readdatavalid),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Behavioural RAM: data appears LAT cycles after the cycle ram_rd is high.
  assign ram_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= ram_rd ? (mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_val(ram_addr)) : 8'hxx;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (ram_wr) mem[int'(ram_addr)] = ram_wdata;
  end

  // Scoreboard: expectations pushed on accept, popped on readdatavalid.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vq.delete();
      cq.delete();
    end else begin
      if (vga_read && !vga_waitrequest) begin
        e.d = ref_mem.exists(int'(vga_address)) ? ref_mem[int'(vga_address)] : init_val(vga_address);
        e.c = cyc;
        vq.push_back(e);
      end
      if ((cpu_read || cpu_write) && !cpu_waitrequest) begin
        if (cpu_write) ref_mem[int'(cpu_address)] = cpu_writedata;
        else begin
          e.d = ref_mem.exists(int'(cpu_address)) ? ref_mem[int'(cpu_address)] : init_val(cpu_address);
          e.c = cyc;
          cq.push_back(e);
        end
      end
    end
    if (vga_readdatavalid) begin
      vga_pulses++;
      checks++;
      if (vq.size() == 0) begin
        failures++;
        $display("FAIL vga_rdv: unexpected pulse data=%h", vga_readdata);
      end else begin
        e = vq.pop_front();
        if (vga_readdata !== e.d || cyc - e.c != LAT + 2) begin
          failures++;
          $display("FAIL vga_rdv: got %h after %0d cycles, expected %h after %0d", vga_readdata, cyc - e.c, e.d, LAT + 2);
        end
      end
    end
    if (cpu_readdatavalid) begin
      cpu_pulses++;
      checks++;
      if (cq.size() == 0) begin
        failures++;
        $display("FAIL cpu_rdv: unexpected pulse data=%h", cpu_readdata);
      end else begin
        e = cq.pop_front();
        if (cpu_readdata !== e.d || cyc - e.c != LAT + 2) begin
          failures++;
          $display("FAIL cpu_rdv: got %h after %0d cycles, expected %h after %0d", cpu_readdata, cyc - e.c, e.d, LAT + 2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((vq.size() != 0 || cq.size() != 0) && n < 30) begin
      step();
      n++;
    end
    step();
    checks++;
    if (vq.size() != 0 || cq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: outstanding vga=%0d cpu=%0d, expected 0", name, vq.size(), cq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ram_rd, ram_wr, ram_addr, ram_wdata, vga_readdata, cpu_readdata, vga_readdatavalid, cpu_readdatavalid} !== '0
        || vga_waitrequest !== 1'b1 || cpu_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%h wd=%h vrd=%h crd=%h vv=%b cv=%b vw=%b cw=%b, expected zeros and waits high",
               ram_rd, ram_wr, ram_addr, ram_wdata, vga_readdata, cpu_readdata, vga_readdatavalid, cpu_readdatavalid,
               vga_waitrequest, cpu_waitrequest);
    end
  endtask

  task automatic test_vga_stream();
    for (int i = 0; i <= 16; i++) begin
      vga_read = (i < 16);
      vga_address = 19'(i);
      @(negedge clk);
      checks++;
      if (i < 16 && vga_waitrequest !== 1'b0) begin
        failures++;
        $display("FAIL stream_wait[%0d]: waitrequest=%b expected 0", i, vga_waitrequest);
      end
      if (i > 0 && (ram_rd !== 1'b1 || ram_addr !== 19'(i - 1))) begin
        failures++;
        $display("FAIL stream_cmd[%0d]: rd=%b addr=%h expected rd=1 addr=%h", i, ram_rd, ram_addr, i - 1);
      end
      step();
    end
    vga_read = 0;
    drain("stream");
  endtask

  task automatic test_write_read();
    cpu_write = 1;
    cpu_address = 19'h123;
    cpu_writedata = 8'h5A;
    @(negedge clk);
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL wr_accept: waitrequest=%b expected 0", cpu_waitrequest);
    end
    step();
    cpu_write = 0;
    cpu_read = 1;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== 19'h123 || ram_wdata !== 8'h5A || cpu_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL wr_cmd: wr=%b rd=%b addr=%h wd=%h wait=%b expected 1 0 123 5a 0", ram_wr, ram_rd, ram_addr, ram_wdata, cpu_waitrequest);
    end
    step();
    cpu_read = 0;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || ram_rd !== 1'b1 || ram_addr !== 19'h123) begin
      failures++;
      $display("FAIL rd_cmd: wr=%b rd=%b addr=%h expected 0 1 123", ram_wr, ram_rd, ram_addr);
    end
    drain("write_read");
    checks++;
    if (cpu_readdata !== 8'h5A) begin
      failures++;
      $display("FAIL raw_data: cpu_readdata=%h expected 5a", cpu_readdata);
    end
  endtask

  task automatic test_starvation();
    int  run = 0;
    logic va, ca;
    vga_read = 1;
    vga_address = 19'h400;
    cpu_read = 1;
    cpu_address = 19'h200;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      va = vga_read && !vga_waitrequest;
      ca = cpu_read && !cpu_waitrequest;
      checks++;
      if (ca !== (run == 8) || va !== !ca) begin
        failures++;
        $display("FAIL starve[%0d]: vga_acc=%b cpu_acc=%b expected cpu_acc=%b", k, va, ca, run == 8);
      end
      run = ca ? 0 : run + 1;
      step();
      if (va) vga_address++;
      if (ca) cpu_address++;
    end
    vga_read = 0;
    cpu_read = 0;
    drain("starve");
  endtask

  task automatic test_simultaneous();
    vga_read = 1;
    vga_address = 19'h40;
    cpu_read = 1;
    cpu_address = 19'h41;
    @(negedge clk);
    checks++;
    if (vga_waitrequest !== 1'b0 || cpu_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL simul_first: vga_wait=%b cpu_wait=%b expected 0 1", vga_waitrequest, cpu_waitrequest);
    end
    step();
    vga_read = 0;
    @(negedge clk);
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL simul_second: cpu_wait=%b expected 0", cpu_waitrequest);
    end
    step();
    cpu_read = 0;
    drain("simul");
  endtask

  task automatic test_reset_mid_read();
    int p0;
    for (int i = 0; i < 3; i++) begin
      vga_read = 1;
      vga_address = 19'h300 + 19'(i);
      step();
    end
    vga_read = 0;
    p0 = vga_pulses;
    rst = 1;
    step();
    @(negedge clk);
    checks++;
    if ({ram_rd, ram_wr, ram_addr, ram_wdata, vga_readdata, cpu_readdata, vga_readdatavalid, cpu_readdatavalid} !== '0) begin
      failures++;
      $display("FAIL midreset_state: rd=%b wr=%b addr=%h wd=%h vrd=%h crd=%h, expected all zero",
               ram_rd, ram_wr, ram_addr, ram_wdata, vga_readdata, cpu_readdata);
    end
    step();
    rst = 0;
    repeat (8) step();
    checks++;
    if (vga_pulses != p0) begin
      failures++;
      $display("FAIL midreset_discard: %0d stale pulses, expected 0", vga_pulses - p0);
    end
    vga_read = 1;
    vga_address = 19'h77;
    step();
    vga_read = 0;
    drain("resume");
    checks++;
    if (vga_pulses != p0 + 1) begin
      failures++;
      $display("FAIL resume_pulses: %0d pulses, expected 1", vga_pulses - p0);
    end
  endtask

  task automatic test_illegal();
    int p0 = cpu_pulses;
    cpu_read = 1;
    cpu_write = 1;
    cpu_address = 19'h10;
    cpu_writedata = 8'hFF;
    @(negedge clk);
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL illegal_accept: waitrequest=%b expected 0", cpu_waitrequest);
    end
    step();
    cpu_read = 0;
    cpu_write = 0;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== 19'h10 || ram_wdata !== 8'hFF) begin
      failures++;
      $display("FAIL illegal_cmd: wr=%b rd=%b addr=%h wd=%h expected 1 0 10 ff", ram_wr, ram_rd, ram_addr, ram_wdata);
    end
    repeat (8) step();
    checks++;
    if (cpu_pulses != p0) begin
      failures++;
      $display("FAIL illegal_resp: %0d cpu pulses, expected 0", cpu_pulses - p0);
    end
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    step();
    rst = 0;
    step();
    test_vga_stream();
    test_write_read();
    test_starvation();
    test_simultaneous();
    test_reset_mid_read();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avmm_vram_arbiter.md
# avmm_vram_arbiter

Arbitrates one single-port synchronous VRAM between two Avalon-MM masters: the display read master of the VGA controller (`vga_*`, read-only, high priority) and a core drawing master (`cpu_*`, read/write). The VRAM is a fixed-latency on-chip or SRAM-style memory. The block sits directly upstream of the VGA controller's VRAM master port, in the `clk_core` domain. Read data is routed back to its requester through a tag pipeline.

## Interface
Parameters:
- `PWIDTH`, 8: pixel/data width.
- `AWIDTH`, 19: VRAM address width.
- `LATENCY`, 2: RAM read latency in cycles from `ram_rd` to `ram_rdata` valid; must be ≥1.
- `VGA_BURST`, 8: maximum consecutive VGA grants while a CPU request waits; must be ≥1.

Ports:
- `clk_core`, in, 1: single clock; all logic on its rising edge.
- `rst_core`, in, 1: reset, synchronous, active-high.
- `vga_address`, in, AWIDTH: VGA read address.
- `vga_read`, in, 1: VGA read request.
- `vga_waitrequest`, out, 1: VGA request not accepted this cycle.
- `vga_readdata`, out, PWIDTH: VGA read data.
- `vga_readdatavalid`, out, 1: `vga_readdata` valid.
- `cpu_address`, in, AWIDTH: CPU address.
- `cpu_read`, in, 1: CPU read request.
- `cpu_write`, in, 1: CPU write request.
- `cpu_writedata`, in, PWIDTH: CPU write data.
- `cpu_waitrequest`, out, 1: CPU request not accepted this cycle.
- `cpu_readdata`, out, PWIDTH: CPU read data.
- `cpu_readdatavalid`, out, 1: `cpu_readdata` valid.
- `ram_addr`, out, AWIDTH: registered RAM address.
- `ram_rd`, out, 1: registered RAM read strobe.
- `ram_wr`, out, 1: registered RAM write strobe.
- `ram_wdata`, out, PWIDTH: registered RAM write data.
- `ram_rdata`, in, PWIDTH: RAM read data, valid LATENCY cycles after `ram_rd`.

## Operation
- Avalon rules:
  - A request is accepted in the cycle where (`read` or `write`) is high and `waitrequest` is low.
  - Masters hold address and data stable while `waitrequest` is high.
  - `cpu_read` and `cpu_write` both high is illegal; the block treats it as a write.
- Grant (combinational, one grant per cycle):
  - `grant_vga` = `vga_read` and not (CPU pending and `starve_cnt` == VGA_BURST).
  - `grant_cpu` = CPU pending and not `grant_vga`.
  - `vga_waitrequest` = `vga_read` and not `grant_vga`.
  - `cpu_waitrequest` = (`cpu_read` or `cpu_write`) and not `grant_cpu`.
  - Both waitrequests are forced high while `rst_core` is high.
- Starvation counter `starve_cnt` (width clog2(VGA_BURST+1)):
  - Increments on a VGA grant while the CPU is pending, saturating at VGA_BURST.
  - Clears on a CPU grant, or in any cycle where the CPU is not pending.
- Command register: the accepted request is loaded into `ram_addr`, `ram_rd`, `ram_wr`, `ram_wdata` at the clock edge. With no grant, `ram_rd` and `ram_wr` are 0 and `ram_addr` and `ram_wdata` hold their values.
- Tag pipeline:
  - LATENCY+1 stages, each {valid, owner}, shifted every cycle.
  - Stage 0 is loaded with {1, VGA/CPU} on an accepted read, otherwise {0, x}.
  - When the last stage is valid, `ram_rdata` is registered into the owner's `readdata` and that owner's `readdatavalid` pulses for one cycle.
  - A non-owner's `readdata` holds its last value.
- Writes produce no response. Read data returns to each master in its issue order; interleaving between masters is allowed.
- Reset (including mid-transfer): tag pipeline cleared, in-flight reads discarded, no `readdatavalid` is produced for requests accepted before reset, `starve_cnt` = 0.

## Timing
- Reset values: `ram_rd`/`ram_wr` = 0, `ram_addr`/`ram_wdata` = 0, both `readdata` = 0, both `readdatavalid` = 0.
- Read accepted in cycle N:
  - `ram_rd` high in cycle N+1.
  - `ram_rdata` valid in N+1+LATENCY.
  - `readdatavalid` high in N+2+LATENCY.
  - Total read latency is LATENCY+2. The VGA controller's LATENCY parameter is set to this value.
- Write accepted in cycle N: `ram_wr` high in N+1.
- Throughput: one accepted request per cycle; back-to-back reads are fully pipelined.
- Zero-cycle waitrequest: an uncontested request is accepted in the same cycle it is asserted.
- Read-after-write to the same address: the write reaches the RAM first, so the read returns the new data.

## Test plan
- Solo VGA stream: LATENCY=2, addresses 0..15 back-to-back -> `vga_waitrequest` always 0; `ram_rd` 16 consecutive cycles; `vga_readdatavalid` 16 consecutive cycles starting 4 cycles after the first accept; data matches the RAM model in order.
- CPU write then read: write 0x5A to address 0x123, then read 0x123 -> `ram_wr` pulses once with addr 0x123 / data 0x5A; `cpu_readdata` = 0x5A, 4 cycles after the read is accepted.
- Starvation: VGA_BURST=8, `vga_read` held high continuously, CPU read pending -> exactly 8 VGA grants, then 1 CPU grant (`vga_waitrequest` high for that single cycle), repeating; the CPU never waits more than 8 cycles.
- Simultaneous arrival: VGA and CPU requests rise in the same cycle with `starve_cnt` = 0 -> VGA accepted; CPU accepted the next cycle; `readdatavalid` returns to the correct owner with correct data.
- Reset mid-read: accept 3 VGA reads, assert `rst_core` one cycle later -> all outputs at reset values the cycle after, zero `readdatavalid` pulses for those reads; normal operation resumes after reset is released.
- Illegal CPU read+write: both high with addr 0x10, data 0xFF -> treated as a write (`ram_wr` = 1, `ram_rd` = 0), no `cpu_readdatavalid`.
